// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the integer execute unit: widths, inside-opcode encodings,
// the op-class enum and small decode helpers.
package alu_pipe_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;

    localparam logic [TAG_W-1:0] ZERO_TAG_ROB = 4'd0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_SLL   = 6'd22,
        OP_SLT   = 6'd23,
        OP_SLTU  = 6'd24,
        OP_XOR   = 6'd25,
        OP_SRL   = 6'd26,
        OP_SRA   = 6'd27,
        OP_OR    = 6'd28,
        OP_AND   = 6'd29
    } op_e;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ARITH  = 3'd1,
        CLS_SHIFT  = 3'd2,
        CLS_CMP    = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JUMP   = 3'd5,
        CLS_UPPER  = 3'd6
    } op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:           return CLS_ARITH;
            OP_SLL, OP_SRL, OP_SRA,
            OP_SLLI, OP_SRLI, OP_SRAI:                   return CLS_SHIFT;
            OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU:          return CLS_CMP;
            OP_BEQ, OP_BNE, OP_BLT,
            OP_BGE, OP_BLTU, OP_BGEU:                    return CLS_BRANCH;
            OP_JAL, OP_JALR:                             return CLS_JUMP;
            OP_LUI, OP_AUIPC:                            return CLS_UPPER;
            default:                                     return CLS_NONE;
        endcase
    endfunction

    // I-type ALU ops take their second operand from the immediate.
    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI:          return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational RV32I execute datapath: result value, control-transfer flag and next pc.
module alu_pipe_core
    import alu_pipe_pkg::*;
(
    input  op_class_e        cls,
    input  logic [OP_W-1:0]  op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  value,
    output logic             jump,
    output logic [XLEN-1:0]  target
);

    logic [XLEN-1:0] pc_next_s;
    logic            cond_s;

    assign pc_next_s = pc + 32'd4;

    // Branch condition evaluation, shared by all six branch flavours.
    always_comb begin
        cond_s = 1'b0;
        case (op)
            OP_BEQ:  cond_s = (a == b);
            OP_BNE:  cond_s = (a != b);
            OP_BLT:  cond_s = ($signed(a) <  $signed(b));
            OP_BGE:  cond_s = ($signed(a) >= $signed(b));
            OP_BLTU: cond_s = (a <  b);
            OP_BGEU: cond_s = (a >= b);
            default: cond_s = 1'b0;
        endcase
    end

    // Result selection by op class; unknown ops fall through to value 0, no jump.
    always_comb begin
        value  = 32'd0;
        jump   = 1'b0;
        target = pc_next_s;
        case (cls)
            CLS_ARITH: begin
                case (op)
                    OP_ADD, OP_ADDI: value = a + b;
                    OP_SUB:          value = a - b;
                    OP_AND, OP_ANDI: value = a & b;
                    OP_OR,  OP_ORI:  value = a | b;
                    OP_XOR, OP_XORI: value = a ^ b;
                    default:         value = 32'd0;
                endcase
            end
            CLS_SHIFT: begin
                case (op)
                    OP_SLL, OP_SLLI: value = a << b[4:0];
                    OP_SRL, OP_SRLI: value = a >> b[4:0];
                    OP_SRA, OP_SRAI: value = XLEN'($signed(a) >>> b[4:0]);
                    default:         value = 32'd0;
                endcase
            end
            CLS_CMP: begin
                case (op)
                    OP_SLT, OP_SLTI:   value = {31'd0, $signed(a) < $signed(b)};
                    OP_SLTU, OP_SLTIU: value = {31'd0, a < b};
                    default:           value = 32'd0;
                endcase
            end
            CLS_UPPER: begin
                if (op == OP_AUIPC) begin
                    value = pc + imm;
                end else begin
                    value = imm;
                end
            end
            CLS_JUMP: begin
                value = pc_next_s;
                jump  = 1'b1;
                if (op == OP_JALR) begin
                    target = (a + imm) & ~32'd1;
                end else begin
                    target = pc + imm;
                end
            end
            CLS_BRANCH: begin
                jump = cond_s;
                if (cond_s) begin
                    target = pc + imm;
                end else begin
                    target = pc_next_s;
                end
            end
            default: begin
                value  = 32'd0;
                jump   = 1'b0;
                target = pc_next_s;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage integer execute unit: S1 captures and pre-decodes an issued entry,
// S2 registers the computed result onto the ALU CDB for exactly one cycle.
module alu_pipe
    import alu_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [OP_W-1:0]   in_rs_op,
    input  logic [XLEN-1:0]   in_rs_value1,
    input  logic [XLEN-1:0]   in_rs_value2,
    input  logic [XLEN-1:0]   in_rs_imm,
    input  logic [TAG_W-1:0]  in_rs_rob_tag,
    input  logic [XLEN-1:0]   in_rs_pc,
    input  logic              in_rob_misbranch,
    output logic [TAG_W-1:0]  out_cdb_tag,
    output logic [XLEN-1:0]   out_cdb_value,
    output logic              out_cdb_jump,
    output logic [XLEN-1:0]   out_cdb_target_pc
);

    logic              s1_valid_r;
    logic [TAG_W-1:0]  s1_tag_r;
    logic [OP_W-1:0]   s1_op_r;
    op_class_e         s1_cls_r;
    logic [XLEN-1:0]   s1_a_r;
    logic [XLEN-1:0]   s1_b_r;
    logic [XLEN-1:0]   s1_pc_r;
    logic [XLEN-1:0]   s1_imm_r;

    logic              issue_s;
    logic [XLEN-1:0]   core_value_s;
    logic              core_jump_s;
    logic [XLEN-1:0]   core_target_s;

    assign issue_s = (in_rs_op != OP_NOP) && (in_rs_rob_tag != ZERO_TAG_ROB);

    alu_pipe_core u_core (
        .cls    (s1_cls_r),
        .op     (s1_op_r),
        .a      (s1_a_r),
        .b      (s1_b_r),
        .pc     (s1_pc_r),
        .imm    (s1_imm_r),
        .value  (core_value_s),
        .jump   (core_jump_s),
        .target (core_target_s)
    );

    // S1 capture with flush; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_tag_r   <= ZERO_TAG_ROB;
            s1_op_r    <= OP_NOP;
            s1_cls_r   <= CLS_NONE;
            s1_a_r     <= 32'd0;
            s1_b_r     <= 32'd0;
            s1_pc_r    <= 32'd0;
            s1_imm_r   <= 32'd0;
        end else if (rdy) begin
            s1_valid_r <= issue_s && !in_rob_misbranch;
            if (issue_s && !in_rob_misbranch) begin
                s1_tag_r <= in_rs_rob_tag;
                s1_op_r  <= in_rs_op;
                s1_cls_r <= op_class(in_rs_op);
                s1_a_r   <= in_rs_value1;
                s1_b_r   <= uses_imm(in_rs_op) ? in_rs_imm : in_rs_value2;
                s1_pc_r  <= in_rs_pc;
                s1_imm_r <= in_rs_imm;
            end
        end
    end

    // S2 broadcast register; idle and flushed cycles drive all zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cdb_tag       <= ZERO_TAG_ROB;
            out_cdb_value     <= 32'd0;
            out_cdb_jump      <= 1'b0;
            out_cdb_target_pc <= 32'd0;
        end else if (rdy) begin
            if (s1_valid_r && !in_rob_misbranch) begin
                out_cdb_tag       <= s1_tag_r;
                out_cdb_value     <= core_value_s;
                out_cdb_jump      <= core_jump_s;
                out_cdb_target_pc <= core_target_s;
            end else begin
                out_cdb_tag       <= ZERO_TAG_ROB;
                out_cdb_value     <= 32'd0;
                out_cdb_jump      <= 1'b0;
                out_cdb_target_pc <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed literal checks plus randomized traffic
// compared every cycle against an op-level behavioural model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
    } bcast_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [31:0] v1 = 32'd0, v2 = 32'd0, imm = 32'd0, pc = 32'd0;
    logic [3:0]  tag = 4'd0;
    logic        misb = 1'b0;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value, cdb_target;
    logic        cdb_jump;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_pipe dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_rs_op(op), .in_rs_value1(v1), .in_rs_value2(v2), .in_rs_imm(imm),
        .in_rs_rob_tag(tag), .in_rs_pc(pc), .in_rob_misbranch(misb),
        .out_cdb_tag(cdb_tag), .out_cdb_value(cdb_value),
        .out_cdb_jump(cdb_jump), .out_cdb_target_pc(cdb_target)
    );

    // Architectural meaning of each instruction, written straight from the ISA.
    function automatic bcast_t ref_exec(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        bcast_t r;
        logic   c;
        r = '{tag: t, value: 32'd0, jump: 1'b0, target: p + 32'd4};
        c = 1'b0;
        case (o)
            OP_ADD:   r.value = a + b;
            OP_ADDI:  r.value = a + i;
            OP_SUB:   r.value = a - b;
            OP_AND:   r.value = a & b;
            OP_ANDI:  r.value = a & i;
            OP_OR:    r.value = a | b;
            OP_ORI:   r.value = a | i;
            OP_XOR:   r.value = a ^ b;
            OP_XORI:  r.value = a ^ i;
            OP_SLL:   r.value = a << (b % 32);
            OP_SLLI:  r.value = a << (i % 32);
            OP_SRL:   r.value = a >> (b % 32);
            OP_SRLI:  r.value = a >> (i % 32);
            OP_SRA:   r.value = $signed(a) >>> (b % 32);
            OP_SRAI:  r.value = $signed(a) >>> (i % 32);
            OP_SLT:   r.value = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTI:  r.value = ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
            OP_SLTU:  r.value = (a < b) ? 32'd1 : 32'd0;
            OP_SLTIU: r.value = (a < i) ? 32'd1 : 32'd0;
            OP_LUI:   r.value = i;
            OP_AUIPC: r.value = p + i;
            OP_JAL:   begin r.value = p + 32'd4; r.jump = 1'b1; r.target = p + i; end
            OP_JALR:  begin r.value = p + 32'd4; r.jump = 1'b1; r.target = (a + i) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (o)
                    OP_BEQ:  c = (a == b);
                    OP_BNE:  c = (a != b);
                    OP_BLT:  c = ($signed(a) < $signed(b));
                    OP_BGE:  c = !($signed(a) < $signed(b));
                    OP_BLTU: c = (a < b);
                    default: c = !(a < b);
                endcase
                r.jump   = c;
                r.target = c ? p + i : p + 32'd4;
            end
            default: r.value = 32'd0;
        endcase
        return r;
    endfunction

    // Model: an entry accepted at one enabled edge is broadcast after the next enabled edge unless flushed.
    bcast_t exp_out = '0;
    bcast_t held    = '0;
    logic   held_v  = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_out = '0;
            held_v  = 1'b0;
        end else if (rdy) begin
            exp_out = (!misb && held_v) ? held : bcast_t'(0);
            held_v  = !misb && op != 6'd0 && tag != 4'd0;
            held    = ref_exec(op, v1, v2, imm, pc, tag);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        vectors++;
        if ({cdb_tag, cdb_value, cdb_jump, cdb_target} !== exp_out) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t got tag=%0d val=%h j=%0b tgt=%h want tag=%0d val=%h j=%0b tgt=%h",
                     $time, cdb_tag, cdb_value, cdb_jump, cdb_target,
                     exp_out.tag, exp_out.value, exp_out.jump, exp_out.target);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        op = o; v1 = a; v2 = b; imm = i; pc = p; tag = t;
    endtask

    // Issue at a negedge, return at the negedge where the result is on the CDB.
    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        drive(o, a, b, i, p, t);
        @(negedge clk);
        drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
    endtask

    logic [5:0] ops [31];
    initial begin
        for (int k = 0; k < 30; k++) ops[k] = 6'(k + 1);
        ops[30] = 6'd63;

        #2;
        chk("reset_tag", {28'd0, cdb_tag}, 32'd0);
        chk("reset_value", cdb_value, 32'd0);
        chk("reset_target", cdb_target, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
        chk("add_tag", {28'd0, cdb_tag}, 32'd3);
        chk("add_value", cdb_value, 32'd12);
        chk("add_jump", {31'd0, cdb_jump}, 32'd0);
        chk("add_target", cdb_target, 32'h204);

        run_op(OP_SRA, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 4'd4);
        chk("sra_value", cdb_value, 32'hF800_0000);
        run_op(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd5);
        chk("sltu_value", cdb_value, 32'd1);
        run_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd6);
        chk("slt_value", cdb_value, 32'd0);

        run_op(OP_BNE, 32'd9, 32'd9, 32'h20, 32'h100, 4'd7);
        chk("bne_jump", {31'd0, cdb_jump}, 32'd0);
        chk("bne_target", cdb_target, 32'h104);
        run_op(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd8);
        chk("blt_jump", {31'd0, cdb_jump}, 32'd1);
        chk("blt_target", cdb_target, 32'h120);

        run_op(OP_JALR, 32'h1003, 32'd0, 32'd0, 32'h40, 4'd9);
        chk("jalr_value", cdb_value, 32'h44);
        chk("jalr_jump", {31'd0, cdb_jump}, 32'd1);
        chk("jalr_target", cdb_target, 32'h1002);

        run_op(6'd63, 32'd3, 32'd4, 32'd5, 32'h80, 4'd10);
        chk("unknown_tag", {28'd0, cdb_tag}, 32'd10);
        chk("unknown_value", cdb_value, 32'd0);

        // Flush at the edge capturing tag 3.
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        @(negedge clk);
        drive(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd2);
        @(negedge clk);
        chk("flush_t1", {28'd0, cdb_tag}, 32'd1);
        drive(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd3);
        misb = 1'b1;
        @(negedge clk);
        misb = 1'b0;
        drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        chk("flush_after", {28'd0, cdb_tag}, 32'd0);
        @(negedge clk);
        chk("flush_after2", {28'd0, cdb_tag}, 32'd0);

        // Asynchronous reset between edges.
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd11);
        @(negedge clk);
        drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk("pre_rst_tag", {28'd0, cdb_tag}, 32'd11);
        #1 rst = 1'b0;
        #1 chk("async_rst_tag", {28'd0, cdb_tag}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Stall three edges with an op sitting in S1.
        drive(OP_SUB, 32'd50, 32'd8, 32'd0, 32'd0, 4'd12);
        @(negedge clk);
        drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_idle", {28'd0, cdb_tag}, 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("stall_tag", {28'd0, cdb_tag}, 32'd12);
        chk("stall_value", cdb_value, 32'd42);

        // Randomized traffic checked by the model compare process.
        for (int n = 0; n < 3000; n++) begin
            drive(ops[$urandom_range(30, 0)],
                  ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : $urandom(),
                  ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : $urandom(),
                  $urandom(), $urandom() & 32'hFFFF_FFFC, 4'($urandom_range(15, 0)));
            if ($urandom_range(9, 0) == 0) op = OP_NOP;
            rdy  = ($urandom_range(9, 0) != 0);
            misb = ($urandom_range(19, 0) == 0);
            @(negedge clk);
        end
        rdy = 1'b1;
        misb = 1'b0;
        drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
